// File: rtl/seg7_scan_ctrl_if.sv
// Interface bundling the scan controller's control, data and display signals.
// The master side is the host/board (drives enable, load, bcd_all and the decoder's seg_in).
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_all;
  logic [6:0]              seg_in;
  logic [3:0]              bcd_out;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;

  modport master (
    output enable, load, bcd_all, seg_in,
    input  bcd_out, seg_out, an_out, frame_done
  );

  modport slave (
    input  enable, load, bcd_all, seg_in,
    output bcd_out, seg_out, an_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Round-robin 7-segment scan controller with inter-digit blanking and frame-aligned updates.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always lit).
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int W         = 4 * NUM_DIGITS;
  localparam int CNT_MAX   = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [W-1:0]          shadow;
  logic [W-1:0]          active;
  logic                  pending;
  logic [3:0]            bcd_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  done_q;

  logic                  slot_start;
  logic                  wrap;
  logic                  commit;
  logic                  nxt_dark;
  logic [IDX_W-1:0]      nxt_idx;
  logic [W-1:0]          nxt_active;
  logic [3:0]            nxt_digit;
  logic [NUM_DIGITS-1:0] nxt_strobe;

  // Decide whether a new digit slot starts on this edge, which digit it is,
  // and which value that slot displays (commits land only on digit-0 slots).
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    slot_start = 1'b0;
    wrap       = 1'b0;
    nxt_idx    = '0;
    case (state)
      IDLE:    slot_start = bus.enable;
      SHOW:    slot_start = bus.enable && !HAS_BLANK && (cnt == DIG_LAST);
      BLANK:   slot_start = bus.enable && (cnt == BLK_LAST);
      default: slot_start = 1'b0;
    endcase

    if (state != IDLE) begin
      if (idx == IDX_LAST) wrap = slot_start;
      else                 nxt_idx = idx + 1'b1;
    end

    commit     = pending && slot_start && ((state == IDLE) || wrap);
    nxt_active = active;
    if ((state == IDLE) && bus.load) nxt_active = bus.bcd_all;
    else if (commit)                 nxt_active = shadow;

    nxt_digit = nxt_active[{nxt_idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    nxt_dark = (nxt_idx != '0) && ((nxt_active >> {nxt_idx, 2'b00}) == '0);
`else
    nxt_dark = 1'b0;
`endif
    nxt_strobe = '1;
    if (!nxt_dark) nxt_strobe[nxt_idx] = 1'b0;
  end

  // Value registers: a load always wins over clearing pending, so a load on
  // the wrap edge waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      active <= nxt_active;
      if (bus.load) begin
        shadow  <= bus.bcd_all;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Scan FSM with registered strobe, decoder input and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      an_q   <= '1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state != IDLE) && !bus.enable) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        bcd_q <= '0;
        an_q  <= '1;
      end else if (slot_start) begin
        state  <= SHOW;
        idx    <= nxt_idx;
        cnt    <= '0;
        bcd_q  <= nxt_digit;
        an_q   <= nxt_strobe;
        done_q <= wrap;
      end else if ((state == SHOW) && (cnt == DIG_LAST)) begin
        state <= BLANK;
        cnt   <= '0;
        an_q  <= '1;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = done_q;
  // Segments follow the decoder combinationally, gated dark while no strobe is active.
  assign bus.seg_out    = (&an_q) ? 7'b0 : bus.seg_in;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random traffic,
// compared against a time-slot reference model (t / slot / frame arithmetic).
module tb_seg7_scan_ctrl;
  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = SLOT * ND;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  assign bus.seg_in = seg7(bus.bcd_out);

  // Reference model: m_t counts cycles since scanning started.
  bit          m_on;
  int          m_t;
  logic [15:0] m_shadow, m_active;
  bit          m_pending;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;
  logic        e_lit;
  logic [3:0]  e_bcd;

  task automatic model_reset();
    m_on = 0; m_t = 0; m_shadow = '0; m_active = '0; m_pending = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input logic [15:0] val);
    bit was_on, frame_start;
    was_on      = m_on;
    frame_start = 0;
    if (was_on) begin
      if (!en) m_on = 0;
      else begin
        m_t++;
        frame_start = (m_t % FRAME == 0);
      end
    end else if (en) begin
      m_on = 1; m_t = 0; frame_start = 1;
    end
    if (frame_start && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    if (ld) begin
      if (!was_on) m_active = val;
      m_shadow  = val;
      m_pending = 1;
    end
  endtask

  task automatic calc_expected();
    int d;
    logic [3:0] code;
    bit dark;
    e_an = '1; e_seg = '0; e_fd = 0; e_lit = 0; e_bcd = '0;
    if (m_on) begin
      d     = (m_t / SLOT) % ND;
      code  = m_active[4*d +: 4];
      e_bcd = code;
      e_fd  = (m_t > 0) && (m_t % FRAME == 0);
      dark  = 0;
`ifdef LEADING_ZERO_BLANK_EN
      dark = (d != 0) && ((m_active >> (4*d)) == 16'h0);
`endif
      if ((m_t % SLOT) < DC && !dark) begin
        e_lit = 1; e_an[d] = 1'b0; e_seg = seg7(code);
      end
    end
  endtask

  task automatic cycle(input bit en, input bit ld, input logic [15:0] val);
    bus.enable = en; bus.load = ld; bus.bcd_all = val;
    @(posedge clk);
    model_edge(en, ld, val);
    #1;
    calc_expected();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 0; bus.load = 0; bus.bcd_all = '0;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.an_out !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b want 1111", bus.an_out); end
    n_tests++; if (bus.bcd_out !== 4'h0) begin n_fail++; $display("FAIL reset_bcd got %h want 0", bus.bcd_out); end
    n_tests++; if (bus.seg_out !== 7'h00) begin n_fail++; $display("FAIL reset_seg got %h want 00", bus.seg_out); end
    n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_basic_scan();
    int last_fd;
    last_fd = -1;
    cycle(1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 2*FRAME + 5; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      n_tests++;
      if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
        n_fail++;
        $display("FAIL basic_scan t=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", m_t, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
      end
      if (e_lit) begin
        n_tests++;
        if (bus.bcd_out !== e_bcd) begin n_fail++; $display("FAIL basic_bcd t=%0d got %h want %h", m_t, bus.bcd_out, e_bcd); end
      end
      if (bus.frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          n_tests++;
          if (i - last_fd != FRAME) begin n_fail++; $display("FAIL frame_period got %0d want %0d", i - last_fd, FRAME); end
        end
        last_fd = i;
      end
    end
  endtask

  task automatic test_midframe_load();
    int guard;
    guard = 0;
    while (!(m_on && ((m_t / SLOT) % ND == 2)) && guard < 2*FRAME) begin
      cycle(1'b1, 1'b0, 16'h0); guard++;
    end
    n_tests++; if (guard >= 2*FRAME) begin n_fail++; $display("FAIL midframe_reach got timeout want digit 2"); end
    cycle(1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < FRAME + 2*SLOT; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      n_tests++;
      if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
        n_fail++;
        $display("FAIL midframe t=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", m_t, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
      end
      if (e_lit) begin
        n_tests++;
        if (bus.bcd_out !== e_bcd) begin n_fail++; $display("FAIL midframe_bcd t=%0d got %h want %h", m_t, bus.bcd_out, e_bcd); end
      end
      if (e_fd) begin
        n_tests++;
        if (bus.bcd_out !== 4'h8) begin n_fail++; $display("FAIL midframe_commit got %h want 8", bus.bcd_out); end
      end
    end
  endtask

  task automatic test_double_load();
    int guard, a_seen, fd_seen;
    guard = 0; a_seen = 0; fd_seen = 0;
    while (!(m_on && (m_t % FRAME == 1)) && guard < 2*FRAME) begin
      cycle(1'b1, 1'b0, 16'h0); guard++;
    end
    cycle(1'b1, 1'b1, 16'hAAAA);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0009);
    for (int i = 0; i < 2*FRAME; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      n_tests++;
      if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
        n_fail++;
        $display("FAIL double_load t=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", m_t, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
      end
      if (e_lit && bus.bcd_out === 4'hA) a_seen++;
      if (e_fd && fd_seen == 0) begin
        fd_seen = 1;
        n_tests++;
        if (bus.bcd_out !== 4'h9) begin n_fail++; $display("FAIL double_load_commit got %h want 9", bus.bcd_out); end
      end
    end
    n_tests++; if (a_seen != 0) begin n_fail++; $display("FAIL double_load_no_A got %0d cycles of A want 0", a_seen); end
    n_tests++; if (fd_seen != 1) begin n_fail++; $display("FAIL double_load_fd got %0d want 1", fd_seen); end
  endtask

  task automatic test_disable();
    int guard;
    guard = 0;
    while (!(m_on && ((m_t / SLOT) % ND == 1) && (m_t % SLOT) == 1) && guard < 2*FRAME) begin
      cycle(1'b1, 1'b0, 16'h0); guard++;
    end
    n_tests++; if (bus.an_out !== 4'b1101) begin n_fail++; $display("FAIL disable_pre got %b want 1101", bus.an_out); end
    cycle(1'b0, 1'b0, 16'h0);
    n_tests++; if (bus.an_out !== 4'hF) begin n_fail++; $display("FAIL disable_an got %b want 1111", bus.an_out); end
    n_tests++; if (bus.seg_out !== 7'h00) begin n_fail++; $display("FAIL disable_seg got %h want 00", bus.seg_out); end
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    n_tests++; if (bus.an_out !== 4'b1110) begin n_fail++; $display("FAIL reenable_an got %b want 1110", bus.an_out); end
    n_tests++; if (bus.bcd_out !== e_bcd) begin n_fail++; $display("FAIL reenable_bcd got %h want %h", bus.bcd_out, e_bcd); end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [2];
    vals[0] = 16'h0070; vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      cycle(1'b1, 1'b1, vals[v]);
      for (int i = 0; i < 2*FRAME + 2; i++) begin
        cycle(1'b1, 1'b0, 16'h0);
        n_tests++;
        if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
          n_fail++;
          $display("FAIL leading_zero val=%h t=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", vals[v], m_t, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
        end
      end
    end
  endtask

  task automatic test_random();
    bit en, ld;
    logic [15:0] val;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 19) != 0);
      ld  = ($urandom_range(0, 11) == 0);
      val = 16'($urandom);
      cycle(en, ld, val);
      n_tests++;
      if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
        n_fail++;
        $display("FAIL random i=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", i, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
      end
      if (e_lit) begin
        n_tests++;
        if (bus.bcd_out !== e_bcd) begin n_fail++; $display("FAIL random_bcd i=%0d got %h want %h", i, bus.bcd_out, e_bcd); end
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b1, 16'h4321);
    for (int i = 0; i < FRAME + 2; i++) cycle(1'b1, 1'b0, 16'h0);
    while (e_lit !== 1'b1 && m_t < 4*FRAME) cycle(1'b1, 1'b0, 16'h0);
    #2 rst_n = 0;
    #1;
    n_tests++; if (bus.an_out !== 4'hF) begin n_fail++; $display("FAIL async_rst_an got %b want 1111", bus.an_out); end
    n_tests++; if (bus.bcd_out !== 4'h0) begin n_fail++; $display("FAIL async_rst_bcd got %h want 0", bus.bcd_out); end
    n_tests++; if (bus.seg_out !== 7'h00) begin n_fail++; $display("FAIL async_rst_seg got %h want 00", bus.seg_out); end
    bus.enable = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < FRAME + 2; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      n_tests++;
      if ({bus.an_out, bus.seg_out, bus.frame_done} !== {e_an, e_seg, e_fd}) begin
        n_fail++;
        $display("FAIL post_reset t=%0d an/seg/fd=%b/%h/%b want %b/%h/%b", m_t, bus.an_out, bus.seg_out, bus.frame_done, e_an, e_seg, e_fd);
      end
      if (e_lit) begin
        n_tests++;
        if (bus.bcd_out !== 4'h0) begin n_fail++; $display("FAIL post_reset_bcd t=%0d got %h want 0", m_t, bus.bcd_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_midframe_load();
    test_double_load();
    test_disable();
    test_leading_zero();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
